// File: rtl/key_scan_ctrl_if.sv
// Hit-event channel from key_scan_ctrl to the judge logic.
// Handshake: a transfer happens on a clk edge where evt_valid && evt_ready; while evt_valid && !evt_ready the master holds evt_valid and evt_lane stable.
interface key_scan_ctrl_if #(
    parameter int LANES = 4
) ();
    localparam int LW = $clog2(LANES);

    logic          evt_valid;
    logic [LW-1:0] evt_lane;
    logic          evt_ready;

    modport master (output evt_valid, output evt_lane, input evt_ready);
    modport slave  (input evt_valid, input evt_lane, output evt_ready);
endinterface

// File: rtl/key_scan_ctrl.sv
// Four-lane button front end: synchronizer, shared sample tick, per-lane debounce,
// press detection, pending flags and a round-robin arbiter feeding one event channel.
module key_scan_ctrl #(
    parameter int LANES      = 4,
    parameter int SAMPLE_DIV = 100000,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] btn_raw,
    input  logic             enable,
    output logic [LANES-1:0] lvl,
    output logic             overrun,
    key_scan_ctrl_if.master  evt
);
    localparam int LW = $clog2(LANES);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(STABLE_CNT) + 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [LANES-1:0] r_sync1, r_sync2;
    logic [DW-1:0]    r_div;
    logic [CW-1:0]    r_cnt [LANES];
    logic [LANES-1:0] r_lvl;
    logic [LANES-1:0] r_pend;
    logic [LW-1:0]    r_ptr;
    logic             r_evt_valid;
    logic [LW-1:0]    r_evt_lane;
    logic             r_overrun;

    logic             w_tick;
    logic [LANES-1:0] w_lvl_nxt;
    logic [CW-1:0]    w_cnt_nxt [LANES];
    logic [LANES-1:0] w_press;
    logic             w_slot_free;
    logic [LW-1:0]    w_scan_idx;
    logic [LW-1:0]    w_gnt_idx;
    logic             w_gnt_any;
    logic [LANES-1:0] w_gnt_mask;
    logic [LANES-1:0] w_pend_nxt;
    logic             w_overrun;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_slot_free = !r_evt_valid || evt.evt_ready;

    // A lane's level flips only after STABLE_CNT consecutive ticks that disagree with it.
    always_comb begin
        w_lvl_nxt = r_lvl;
        for (int i = 0; i < LANES; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_tick) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    w_lvl_nxt[i] = ~r_lvl[i];
                    w_cnt_nxt[i] = '0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
        w_press = w_lvl_nxt & ~r_lvl;
    end

    always_comb begin
        w_scan_idx = '0;
        w_gnt_idx  = '0;
        w_gnt_any  = 1'b0;
        for (int k = 1; k <= LANES; k++) begin
            w_scan_idx = LW'((int'(r_ptr) + k) % LANES);
            if (!w_gnt_any && r_pend[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
        if (!enable || !w_slot_free) begin
            w_gnt_any = 1'b0;
        end
    end

    // A press on the lane being granted this cycle re-arms it instead of counting as lost.
    always_comb begin
        w_gnt_mask = w_gnt_any ? ({{(LANES-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;
        if (!enable) begin
            w_pend_nxt = '0;
            w_overrun  = 1'b0;
        end else begin
            w_pend_nxt = (r_pend & ~w_gnt_mask) | w_press;
            w_overrun  = |(w_press & r_pend & ~w_gnt_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_div       <= '0;
            r_lvl       <= '0;
            r_pend      <= '0;
            r_ptr       <= LW'(LANES - 1);
            r_evt_valid <= 1'b0;
            r_evt_lane  <= '0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_div     <= w_tick ? '0 : r_div + DW'(1);
            r_lvl     <= w_lvl_nxt;
            r_pend    <= w_pend_nxt;
            r_overrun <= w_overrun;
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            if (!enable) begin
                r_evt_valid <= 1'b0;
            end else if (w_slot_free) begin
                r_evt_valid <= w_gnt_any;
                if (w_gnt_any) begin
                    r_evt_lane <= w_gnt_idx;
                    r_ptr      <= w_gnt_idx;
                end
            end
        end
    end

    assign lvl           = r_lvl;
    assign overrun       = r_overrun;
    assign evt.evt_valid = r_evt_valid;
    assign evt.evt_lane  = r_evt_lane;

endmodule
